// File: rtl/bus_owner_sequencer.sv
// Hands the CPU main bus between the microcoded pipeline and one external master.
// Optional break/halt support is compiled in with `define BREAK_HALT_EN.
module bus_owner_sequencer #(
  parameter int DRAIN_CYCLES = 2,
  parameter int MAX_HOLD     = 16,
  parameter int CPU_GAP      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_bus_request,
  input  logic       break_in,
  input  logic       resume,
  input  logic       ext_req,
  output logic       ext_grant,
  output logic       fetch_suppress,
  output logic       halted,
  output logic [2:0] state_out
);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    DRAIN = 3'd1,
    EXT   = 3'd2,
    TURN  = 3'd3,
    GAP   = 3'd4,
    HALT  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] hold_q, hold_d;
  logic       expiry_q, expiry_d;
  logic       halt_ret_q, halt_ret_d;
  logic       ext_grant_q, fetch_suppress_q, halted_q;
  logic       brk_w, resume_w;

`ifdef BREAK_HALT_EN
  assign brk_w    = break_in;
  assign resume_w = resume;
`else
  logic unused_break_w;
  assign unused_break_w = break_in ^ resume;
  assign brk_w    = 1'b0;
  assign resume_w = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    expiry_d   = expiry_q;
    halt_ret_d = halt_ret_q;
    case (state_q)
      RUN: begin
        if (brk_w) begin
          state_d = HALT;
        end else if (ext_req && !cpu_bus_request) begin
          state_d = DRAIN;
          cnt_d   = 8'(DRAIN_CYCLES);
        end
      end
      DRAIN: begin
        if (!ext_req) begin
          state_d = TURN;
          cnt_d   = 8'd0;
        end else if (cnt_q <= 8'd1) begin
          state_d = EXT;
          cnt_d   = 8'd0;
          hold_d  = 8'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      EXT: begin
        // A voluntary release wins over a simultaneous expiry and sets no flag.
        if (!ext_req) begin
          state_d = TURN;
        end else if ((MAX_HOLD != 0) && (hold_q >= 8'(MAX_HOLD))) begin
          state_d  = TURN;
          expiry_d = 1'b1;
        end else if (hold_q != 8'hFF) begin
          hold_d = hold_q + 8'd1;
        end
      end
      TURN: begin
        expiry_d   = 1'b0;
        halt_ret_d = 1'b0;
        hold_d     = 8'd0;
        if (halt_ret_q) begin
          state_d = HALT;
        end else if (expiry_q && (CPU_GAP > 0)) begin
          state_d = GAP;
          cnt_d   = 8'(CPU_GAP);
        end else begin
          state_d = RUN;
        end
      end
      GAP: begin
        if (brk_w) begin
          state_d = HALT;
          cnt_d   = 8'd0;
        end else if (cnt_q <= 8'd1) begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HALT: begin
        if (resume_w) begin
          state_d = RUN;
        end else if (ext_req) begin
          state_d    = DRAIN;
          cnt_d      = 8'(DRAIN_CYCLES);
          halt_ret_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= RUN;
      cnt_q            <= 8'd0;
      hold_q           <= 8'd0;
      expiry_q         <= 1'b0;
      halt_ret_q       <= 1'b0;
      ext_grant_q      <= 1'b0;
      fetch_suppress_q <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      hold_q           <= hold_d;
      expiry_q         <= expiry_d;
      halt_ret_q       <= halt_ret_d;
      ext_grant_q      <= (state_d == EXT);
      fetch_suppress_q <= (state_d == DRAIN) || (state_d == EXT) ||
                          (state_d == TURN)  || (state_d == HALT);
      halted_q         <= (state_d == HALT);
    end
  end

  assign ext_grant      = ext_grant_q;
  assign fetch_suppress = fetch_suppress_q;
  assign halted         = halted_q;
  assign state_out      = state_q;

endmodule

// File: tb/tb_bus_owner_sequencer.sv
// Directed bench for bus_owner_sequencer at default parameters; break/halt
// sequence runs only when BREAK_HALT_EN is defined.
module tb_bus_owner_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_bus_request;
  logic       break_in;
  logic       resume;
  logic       ext_req;
  logic       ext_grant;
  logic       fetch_suppress;
  logic       halted;
  logic [2:0] state_out;

  int total = 0;
  int bad   = 0;

  bus_owner_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_bus_request(cpu_bus_request),
    .break_in       (break_in),
    .resume         (resume),
    .ext_req        (ext_req),
    .ext_grant      (ext_grant),
    .fetch_suppress (fetch_suppress),
    .halted         (halted),
    .state_out      (state_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end else begin
      $display("ok   %s: %0d at %0t", tag, obs, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // state, grant, suppress, halted in one go
  task automatic chk_all(input string tag, input logic [2:0] st, input logic g,
                         input logic fs, input logic h);
    chk({tag, ".state"}, 8'(state_out), 8'(st));
    chk({tag, ".grant"}, 8'(ext_grant), 8'(g));
    chk({tag, ".fsup"},  8'(fetch_suppress), 8'(fs));
    chk({tag, ".halt"},  8'(halted), 8'(h));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cpu_bus_request = 1'b0; break_in = 1'b0; resume = 1'b0; ext_req = 1'b0;
    step(); step();
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0);
    ext_req = 1'b1;
    step();
    chk("reset_hold.state", 8'(state_out), 8'd0);

    // Release reset between edges with ext_req high: grant on the 3rd edge.
    rst_n = 1'b1;
    step(); chk_all("lat1", 3'd1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("lat2", 3'd1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("lat3", 3'd2, 1'b1, 1'b1, 1'b0);

    // Hold expiry: 16 granted cycles, 1 turn, 4 gap, then regrant.
    for (int i = 2; i <= 16; i++) begin
      step(); chk($sformatf("hold%0d.grant", i), 8'(ext_grant), 8'd1);
    end
    step(); chk_all("expire_turn", 3'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      step(); chk_all($sformatf("gap%0d", i), 3'd4, 1'b0, 1'b0, 1'b0);
    end
    step(); chk_all("post_gap", 3'd0, 1'b0, 1'b0, 1'b0);
    step(); chk_all("regrant_d1", 3'd1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("regrant_d2", 3'd1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("regrant", 3'd2, 1'b1, 1'b1, 1'b0);

    // Voluntary release: grant drops on the next edge, one turn cycle.
    ext_req = 1'b0;
    step(); chk_all("rel_turn", 3'd3, 1'b0, 1'b1, 1'b0);
    step(); chk_all("rel_run", 3'd0, 1'b0, 1'b0, 1'b0);

    // Contention: the CPU keeps the bus while it requests it.
    cpu_bus_request = 1'b1; ext_req = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step(); chk_all($sformatf("cont%0d", i), 3'd0, 1'b0, 1'b0, 1'b0);
    end
    cpu_bus_request = 1'b0;
    step(); chk_all("cont_d1", 3'd1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("cont_d2", 3'd1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("cont_grant", 3'd2, 1'b1, 1'b1, 1'b0);

    // Async reset mid-grant, no clock edge in between.
    #2 rst_n = 1'b0;
    #1 chk("async.grant", 8'(ext_grant), 8'd0);
    chk("async.state", 8'(state_out), 8'd0);
    chk("async.fsup", 8'(fetch_suppress), 8'd0);
    @(negedge clk);

    // Early release in the first drain cycle.
    rst_n = 1'b1;
    step(); chk_all("early_d1", 3'd1, 1'b0, 1'b1, 1'b0);
    ext_req = 1'b0;
    step(); chk_all("early_turn", 3'd3, 1'b0, 1'b1, 1'b0);
    step(); chk_all("early_run", 3'd0, 1'b0, 1'b0, 1'b0);

`ifdef BREAK_HALT_EN
    break_in = 1'b1; ext_req = 1'b1;
    step(); chk_all("brk_halt", 3'd5, 1'b0, 1'b1, 1'b1);
    break_in = 1'b0;
    step(); chk_all("halt_d1", 3'd1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("halt_d2", 3'd1, 1'b0, 1'b1, 1'b0);
    step(); chk_all("halt_ext", 3'd2, 1'b1, 1'b1, 1'b0);
    ext_req = 1'b0;
    step(); chk_all("halt_turn", 3'd3, 1'b0, 1'b1, 1'b0);
    step(); chk_all("halt_back", 3'd5, 1'b0, 1'b1, 1'b1);
    resume = 1'b1; ext_req = 1'b1;
    step(); chk_all("resume", 3'd0, 1'b0, 1'b0, 1'b0);
    resume = 1'b0; ext_req = 1'b0;
`else
    // Without the halt feature break_in and resume do nothing.
    break_in = 1'b1; resume = 1'b1;
    step(); chk_all("brk_ignored", 3'd0, 1'b0, 1'b0, 1'b0);
    break_in = 1'b0; resume = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
